// File: rtl/irr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irr_pkg
// Purpose  : Shared state encoding, moisture codes and level check for irrigation_ctrl.
// Revision : 1.0
// ============================================================================
package irr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIP     = 2'b01,
        SPRINKLE = 2'b10,
        FAULT    = 2'b11
    } state_t;

    localparam logic [1:0] UA_DRY = 2'b00;
    localparam logic [1:0] UA_LOW = 2'b01;
    localparam logic [1:0] UA_OK  = 2'b10;
    localparam logic [1:0] UA_WET = 2'b11;

    // Sensors are stacked, so water at a level implies water at every level below it.
    function automatic logic level_ok(input logic [2:0] hml);
        return (hml == 3'b000) || (hml == 3'b001) || (hml == 3'b011) || (hml == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deb_filter.sv
`default_nettype none
// ============================================================================
// Module   : deb_filter
// Purpose  : Two-flop synchroniser followed by a DEB_CYC-cycle debounce filter.
// Revision : 1.0
// ============================================================================
module deb_filter #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int c_cnt_w = $clog2(DEB_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEB_CYC - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_cnt;

    // A one-bit input can only change by returning to dout, so the equality
    // test also covers the restart-on-change case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
            dout   <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            if (r_sync == dout) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                dout  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irrigation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irrigation_ctrl
// Purpose  : Sensor filtering, valve state machine and display paging for irrigation.
// Revision : 1.0
// ============================================================================
module irrigation_ctrl
    import irr_pkg::*;
#(
    parameter int DEB_CYC  = 4,
    parameter int MIN_ON   = 16,
    parameter int PAGE_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sh,
    input  logic       sm,
    input  logic       sl,
    input  logic [1:0] ua,
    input  logic       en,
    output logic       h,
    output logic       m,
    output logic       l,
    output logic       vs,
    output logic       bs,
    output logic       m7,
    output logic       fault
);

    localparam int c_tick_w = $clog2(MIN_ON + 1);
    localparam int c_page_w = $clog2(PAGE_CYC + 1);
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(MIN_ON - 1);
    localparam logic [c_page_w-1:0] c_page_max = c_page_w'(PAGE_CYC - 1);

    logic [5:0]          w_raw;
    logic [5:0]          w_filt;
    logic [1:0]          w_ua;
    logic                w_en;
    logic                w_level_ok;
    logic                w_dry;
    logic                w_low;
    state_t              r_state;
    logic [c_tick_w-1:0] r_tick;
    logic [c_page_w-1:0] r_page;

    assign w_raw = {sh, sm, sl, ua, en};

    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
        deb_filter #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (w_raw[gi]),
            .dout  (w_filt[gi])
        );
    end

    assign h          = w_filt[5];
    assign m          = w_filt[4];
    assign l          = w_filt[3];
    assign w_ua       = w_filt[2:1];
    assign w_en       = w_filt[0];
    assign w_level_ok = level_ok({w_filt[5], w_filt[4], w_filt[3]});
    assign w_dry      = (w_ua == UA_DRY);
    assign w_low      = (w_ua == UA_LOW);

    // Valve flags are set alongside each state change so they always mirror r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
            vs      <= 1'b0;
            bs      <= 1'b0;
            fault   <= 1'b0;
        end else begin
            fault <= ~w_level_ok;
            if (!w_level_ok) begin
                r_state <= FAULT;
                vs      <= 1'b0;
                bs      <= 1'b0;
            end else begin
                case (r_state)
                    FAULT: begin
                        r_state <= IDLE;
                    end
                    IDLE: begin
                        if (w_en && l && w_dry && m) begin
                            r_state <= SPRINKLE;
                            vs      <= 1'b1;
                            r_tick  <= '0;
                        end else if (w_en && l && (w_low || (w_dry && !m))) begin
                            r_state <= DRIP;
                            bs      <= 1'b1;
                            r_tick  <= '0;
                        end
                    end
                    DRIP, SPRINKLE: begin
                        if (!l) begin
                            r_state <= IDLE;
                            vs      <= 1'b0;
                            bs      <= 1'b0;
                        end else if ((r_state == SPRINKLE) && !m) begin
                            r_state <= DRIP;
                            vs      <= 1'b0;
                            bs      <= 1'b1;
                            r_tick  <= '0;
                        end else if ((w_ua[1] || !w_en) && (r_tick == c_tick_max)) begin
                            r_state <= IDLE;
                            vs      <= 1'b0;
                            bs      <= 1'b0;
                        end else if (r_tick != c_tick_max) begin
                            r_tick <= r_tick + c_tick_w'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        vs      <= 1'b0;
                        bs      <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page <= '0;
            m7     <= 1'b0;
        end else if (r_page == c_page_max) begin
            r_page <= '0;
            m7     <= ~m7;
        end else begin
            r_page <= r_page + c_page_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irrigation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irrigation_ctrl
// Purpose  : Directed self-checking bench for irrigation_ctrl.
// Revision : 1.0
// ============================================================================
module tb_irrigation_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sh;
    logic       sm;
    logic       sl;
    logic [1:0] ua;
    logic       en;
    logic       h;
    logic       m;
    logic       l;
    logic       vs;
    logic       bs;
    logic       m7;
    logic       fault;

    int checks = 0;
    int errors = 0;

    irrigation_ctrl #(.DEB_CYC(4), .MIN_ON(16), .PAGE_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sh    (sh),
        .sm    (sm),
        .sl    (sl),
        .ua    (ua),
        .en    (en),
        .h     (h),
        .m     (m),
        .l     (l),
        .vs    (vs),
        .bs    (bs),
        .m7    (m7),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic a, input logic b, input logic c,
                               input logic [1:0] u, input logic e);
        rst_n = 1'b0;
        sh = a; sm = b; sl = c; ua = u; en = e;
        step(2);
        rst_n = 1'b1;
        step(8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sh = 1'b1; sm = 1'b1; sl = 1'b1; ua = 2'b11; en = 1'b1;
        step(2);
        checks++; if ({h, m, l, vs, bs, m7, fault} !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b exp 0000000", {h, m, l, vs, bs, m7, fault}); end
        rst_n = 1'b1;
        step(5);
        checks++; if ({h, m, l} !== 3'b000) begin errors++; $display("FAIL level_before_6 got %b exp 000", {h, m, l}); end
        step(1);
        checks++; if ({h, m, l} !== 3'b111) begin errors++; $display("FAIL level_at_6 got %b exp 111", {h, m, l}); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        step(1);
        checks++; if ({vs, bs, fault} !== 3'b000) begin errors++; $display("FAIL wet_idle got %b exp 000", {vs, bs, fault}); end
    endtask

    task automatic test_min_on;
        ua = 2'b00;
        step(6);
        checks++; if (vs !== 1'b0) begin errors++; $display("FAIL sprinkle_early got %b exp 0", vs); end
        step(1);
        checks++; if ({vs, bs} !== 2'b10) begin errors++; $display("FAIL sprinkle_on got %b exp 10", {vs, bs}); end
        ua = 2'b10;
        step(15);
        checks++; if (vs !== 1'b1) begin errors++; $display("FAIL min_on_hold got %b exp 1", vs); end
        step(1);
        checks++; if ({vs, bs} !== 2'b00) begin errors++; $display("FAIL min_on_close got %b exp 00", {vs, bs}); end
    endtask

    task automatic test_glitch;
        ua = 2'b01;
        step(6);
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL drip_early got %b exp 0", bs); end
        step(1);
        checks++; if ({vs, bs} !== 2'b01) begin errors++; $display("FAIL drip_on got %b exp 01", {vs, bs}); end
        sl = 1'b0;
        step(3);
        sl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++; if ({l, bs, fault} !== 3'b110) begin errors++; $display("FAIL glitch_cycle%0d got %b exp 110", i, {l, bs, fault}); end
        end
    endtask

    task automatic test_sprinkle_to_drip;
        apply_reset(1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
        checks++; if ({vs, bs} !== 2'b10) begin errors++; $display("FAIL s2d_sprinkle got %b exp 10", {vs, bs}); end
        sm = 1'b0;
        step(6);
        checks++; if ({m, vs} !== 2'b01) begin errors++; $display("FAIL s2d_m_fall got %b exp 01", {m, vs}); end
        step(1);
        checks++; if ({vs, bs} !== 2'b01) begin errors++; $display("FAIL s2d_switch got %b exp 01", {vs, bs}); end
        sl = 1'b0;
        step(6);
        checks++; if ({l, bs} !== 2'b01) begin errors++; $display("FAIL empty_l_fall got %b exp 01", {l, bs}); end
        step(1);
        checks++; if ({vs, bs, fault} !== 3'b000) begin errors++; $display("FAIL empty_close got %b exp 000", {vs, bs, fault}); end
    endtask

    task automatic test_fault;
        apply_reset(1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        checks++; if (vs !== 1'b1) begin errors++; $display("FAIL fault_pre got %b exp 1", vs); end
        sm = 1'b0;
        step(6);
        checks++; if ({fault, vs} !== 2'b01) begin errors++; $display("FAIL fault_early got %b exp 01", {fault, vs}); end
        step(1);
        checks++; if ({fault, vs, bs} !== 3'b100) begin errors++; $display("FAIL fault_set got %b exp 100", {fault, vs, bs}); end
        sm = 1'b1;
        step(6);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_hold got %b exp 1", fault); end
        step(1);
        checks++; if ({fault, vs, bs} !== 3'b000) begin errors++; $display("FAIL fault_clear got %b exp 000", {fault, vs, bs}); end
        step(1);
        checks++; if (vs !== 1'b1) begin errors++; $display("FAIL fault_resprinkle got %b exp 1", vs); end
        sl = 1'b0;
        step(7);
        checks++; if ({fault, vs, bs} !== 3'b100) begin errors++; $display("FAIL invalid_and_empty got %b exp 100", {fault, vs, bs}); end
    endtask

    task automatic test_page_and_reset;
        rst_n = 1'b0;
        sh = 1'b0; sm = 1'b0; sl = 1'b0; ua = 2'b00; en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(63);
        checks++; if (m7 !== 1'b0) begin errors++; $display("FAIL page_63 got %b exp 0", m7); end
        step(1);
        checks++; if (m7 !== 1'b1) begin errors++; $display("FAIL page_64 got %b exp 1", m7); end
        step(63);
        checks++; if (m7 !== 1'b1) begin errors++; $display("FAIL page_127 got %b exp 1", m7); end
        step(1);
        checks++; if (m7 !== 1'b0) begin errors++; $display("FAIL page_128 got %b exp 0", m7); end
        step(63);
        checks++; if (m7 !== 1'b0) begin errors++; $display("FAIL page_191 got %b exp 0", m7); end
        step(1);
        checks++; if (m7 !== 1'b1) begin errors++; $display("FAIL page_192 got %b exp 1", m7); end
        sh = 1'b1; sm = 1'b1; sl = 1'b1; en = 1'b1;
        step(8);
        checks++; if ({vs, m7} !== 2'b11) begin errors++; $display("FAIL pre_async got %b exp 11", {vs, m7}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({h, vs, bs, m7} !== 4'b0000) begin errors++; $display("FAIL async_reset got %b exp 0000", {h, vs, bs, m7}); end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0;
        sh = 1'b1; sm = 1'b1; sl = 1'b1; ua = 2'b11; en = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_min_on();
        test_glitch();
        test_sprinkle_to_drip();
        test_fault();
        test_page_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irrigation_ctrl.md
# irrigation_ctrl

Control stage that feeds the seven-segment decoders of the automated irrigation system. Synchronises and debounces the raw tank-level and soil-moisture sensors and runs the valve state machine that selects sprinkler or drip irrigation. Publishes registered flags to every segment decoder: filtered tank level h/m/l, valve states vs/bs and display page m7.

## Interface
- DEB_CYC, 4: consecutive stable cycles before a synchronised sensor bit is accepted (≥1)
- MIN_ON, 16: minimum cycles a valve stays open before a moisture/enable-driven close (≥1)
- PAGE_CYC, 64: cycles per display page before m7 toggles (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sh, sm, sl  in  1 each  raw tank sensors high/mid/low (1 = water present), asynchronous
- ua  in  2  raw soil moisture: 00 dry, 01 low, 10 ok, 11 wet; asynchronous
- en  in  1  irrigation enable switch, asynchronous
- h, m, l  out  1 each  filtered tank level
- vs  out  1  sprinkler valve open
- bs  out  1  drip valve open
- m7  out  1  display page: 0 = level page, 1 = irrigation page
- fault  out  1  inconsistent level sensors

## Operation
- Every raw input bit (sh, sm, sl, ua[1], ua[0], en) passes through its own two-flop synchroniser and debounce filter. Filter counter clears whenever the synchronised bit equals the filtered bit or changes. The filtered bit takes the new value when that value has been stable DEB_CYC consecutive cycles.
- Level sensor combinations:
  - Valid combinations are 000, 001, 011, 111 ({h,m,l}).
  - Any other combination is invalid: fault = 1, and the FSM goes to FAULT.
- FSM states are IDLE, DRIP, SPRINKLE, FAULT. A tick counter starts at 0 on entry to DRIP or SPRINKLE and saturates at MIN_ON-1. "dry" means ua==00; "low" means ua==01.
- Transition priority, highest first, evaluated every cycle on filtered values:
  1. Invalid level → FAULT from any state.
  2. FAULT, once the level is valid → IDLE.
  3. DRIP or SPRINKLE with l==0 (tank empty) → IDLE immediately, ignoring MIN_ON.
  4. SPRINKLE with m==0 → DRIP, counter restarts.
  5. DRIP or SPRINKLE with (ua[1]==1 or en==0) and counter==MIN_ON-1 → IDLE.
  6. IDLE with en & l & dry & m → SPRINKLE.
  7. IDLE with en & l & (low, or dry & ~m) → DRIP.
- DRIP never promotes to SPRINKLE. Rising level with dry soil is handled only after returning to IDLE.
- Valve outputs: vs = (state==SPRINKLE), bs = (state==DRIP). They are never both 1.
- Page counter: free-running, counts 0..PAGE_CYC-1, wraps to 0. m7 toggles on the wrap.
- Unaffected by FSM state.

## Timing
- Reset (asynchronous assert, synchronous release on clk):
  - state = IDLE; all counters = 0; synchroniser and filter flops = 0.
  - h = m = l = vs = bs = m7 = fault = 0.
- Raw edge to filtered output: 2 + DEB_CYC rising edges, for a clean edge.
- A glitch shorter than DEB_CYC synchronised cycles never reaches the filtered outputs.
- Filtered change to vs/bs/fault: 1 cycle. All outputs come straight from flops with no combinational paths from inputs.
- Minimum valve-open time for a moisture/enable-driven close: exactly MIN_ON cycles of vs or bs high.
- m7: first toggle PAGE_CYC cycles after reset release, then every PAGE_CYC cycles.
- Simultaneous events: the priority list above decides. For example, invalid level together with empty tank gives FAULT.
- Reset mid-irrigation: valves close asynchronously; no state is retained.

## Structure
- Shared package irr_pkg:
  - state encoding constants IDLE=2'b00, DRIP=2'b01, SPRINKLE=2'b10, FAULT=2'b11
  - moisture codes UA_DRY, UA_LOW, UA_OK, UA_WET
- Sub-module deb_filter: one-bit two-flop synchroniser plus debounce counter, parameter DEB_CYC, ports clk, rst_n, din, dout. Instantiated six times.
- The top level holds the level checker, FSM, tick counter and page counter.

## Test plan
- Reset with all inputs 1 → all outputs 0. After release, h/m/l = 1 exactly 2+4 = 6 edges later, and fault stays 0.
- {sh,sm,sl} = 111, ua = 00, en = 1 → vs = 1 one cycle after filtered. Then ua = 10 → vs stays high until it has been high 16 cycles in total, then falls.
- 3-cycle pulse on sl while in DRIP → l, bs and fault unchanged (glitch rejected).
- SPRINKLE, then sm = 0 → vs = 0 and bs = 1 in the same cycle. Then sl = 0 → bs = 0 one cycle after l falls, ignoring MIN_ON.
- {sh,sm,sl} = 101 during SPRINKLE → fault = 1 and vs = 0. Restore 111 → fault = 0 and state IDLE, then re-enters SPRINKLE since dry.
- Idle run → m7 toggles at cycles 64, 128, 192 after reset release. Asserting rst_n low mid-irrigation clears vs/bs/m7 immediately.
